// File: rtl/bin2dec_seq_if.sv
// Handshake bundle between a result producer and the bin2dec_seq converter.
// Carries the start/value request, the ready/done status and the converted result.
// master drives the request; slave (the converter) drives status and result.
interface bin2dec_seq_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) ();
    localparam int NDW = $clog2(DIGITS + 1);

    logic                  start;
    logic [WIDTH-1:0]      value;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  negative;
    logic [NDW-1:0]        num_digits;

    modport master (
        output start, value,
        input  ready, done, bcd, negative, num_digits
    );

    modport slave (
        input  start, value,
        output ready, done, bcd, negative, num_digits
    );
endinterface

// File: rtl/bin2dec_seq.sv
// Iterative double-dabble binary-to-BCD converter with sign and digit count.
// Latency: start accepted at E0, done pulses after edge E(WIDTH+1).
// Backpressure: ready=0 while busy; start during busy is dropped, not queued.
module bin2dec_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10,
    parameter bit SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    bin2dec_seq_if.slave   bus
);
    localparam int NDW = $clog2(DIGITS + 1);
    localparam int CW  = $clog2(WIDTH + 1);
    // ceil(WIDTH * log10(2)) in integer arithmetic
    localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;

    if (DIGITS < MIN_DIGITS) begin : g_digits_too_small
        $error("bin2dec_seq: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [WIDTH-1:0]      mag;
    logic [4*DIGITS-1:0]   work;
    logic                  neg;

    logic                  in_neg;
    logic [WIDTH-1:0]      in_mag;
    logic [4*DIGITS-1:0]   work_adj;
    logic [NDW-1:0]        sig_digits;

    // Sign and magnitude of the incoming value; the most negative value maps to 2^(WIDTH-1)
    always_comb begin
        in_neg = SIGNED && bus.value[WIDTH-1];
        in_mag = bus.value;
        if (in_neg) begin
            in_mag = (~bus.value) + WIDTH'(1);
        end
    end

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    always_comb begin
        work_adj = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] >= 4'd5) begin
                work_adj[4*k +: 4] = work[4*k +: 4] + 4'd3;
            end
        end
    end

    // Highest non-zero digit position + 1; zero still shows one digit
    always_comb begin
        sig_digits = NDW'(1);
        for (int k = 0; k < DIGITS; k++) begin
            if (work[4*k +: 4] != 4'd0) begin
                sig_digits = NDW'(k + 1);
            end
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            mag            <= '0;
            work           <= '0;
            neg            <= 1'b0;
            bus.ready      <= 1'b1;
            bus.done       <= 1'b0;
            bus.bcd        <= '0;
            bus.negative   <= 1'b0;
            bus.num_digits <= NDW'(1);
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        neg       <= in_neg;
                        mag       <= in_mag;
                        work      <= '0;
                        cnt       <= CW'(WIDTH);
                        state     <= SHIFT;
                        bus.ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    // magnitude MSB enters digit 0 LSB
                    work <= {work_adj[4*DIGITS-2:0], mag[WIDTH-1]};
                    mag  <= {mag[WIDTH-2:0], 1'b0};
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.bcd        <= work;
                    bus.negative   <= neg;
                    bus.num_digits <= sig_digits;
                    bus.done       <= 1'b1;
                    bus.ready      <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin2dec_seq.sv
// Self-checking bench for bin2dec_seq: signed and unsigned 32-bit instances.
// Table-driven conversions plus hand sequences for ignored start, back-to-back and reset abort.
module tb_bin2dec_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin2dec_seq_if #(.WIDTH(32), .DIGITS(10)) bs ();
    bin2dec_seq_if #(.WIDTH(32), .DIGITS(10)) bu ();

    bin2dec_seq #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b1)) u_signed (
        .clk(clk), .rst(rst), .bus(bs)
    );
    bin2dec_seq #(.WIDTH(32), .DIGITS(10), .SIGNED(1'b0)) u_unsigned (
        .clk(clk), .rst(rst), .bus(bu)
    );

    typedef struct {
        bit          uns;
        logic [31:0] value;
        logic [39:0] bcd;
        bit          neg;
        int          nd;
        string       name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input bit uns);
        return uns ? bu.done : bs.done;
    endfunction

    function automatic logic get_ready(input bit uns);
        return uns ? bu.ready : bs.ready;
    endfunction

    function automatic logic [39:0] get_bcd(input bit uns);
        return uns ? bu.bcd : bs.bcd;
    endfunction

    function automatic logic get_neg(input bit uns);
        return uns ? bu.negative : bs.negative;
    endfunction

    function automatic logic [3:0] get_nd(input bit uns);
        return uns ? bu.num_digits : bs.num_digits;
    endfunction

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge
    task automatic pulse_start(input bit uns, input logic [31:0] v);
        if (uns) begin bu.start = 1'b1; bu.value = v; end
        else     begin bs.start = 1'b1; bs.value = v; end
        @(posedge clk); #1;
        bu.start = 1'b0;
        bs.start = 1'b0;
    endtask

    task automatic do_conv(input bit uns, input logic [31:0] v, input logic [39:0] exp_bcd,
                           input bit exp_neg, input int exp_nd, input string tag);
        int lat;
        check({tag, " ready_before"}, get_ready(uns), 1);
        pulse_start(uns, v);
        check({tag, " ready_busy"}, get_ready(uns), 0);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (get_done(uns)) lat = n;
        end
        check({tag, " latency"}, lat, 33);
        check({tag, " bcd"}, get_bcd(uns), exp_bcd);
        check({tag, " negative"}, get_neg(uns), exp_neg);
        check({tag, " num_digits"}, get_nd(uns), exp_nd);
        check({tag, " ready_done"}, get_ready(uns), 1);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, get_done(uns), 0);
        check({tag, " bcd_hold"}, get_bcd(uns), exp_bcd);
    endtask

    initial begin
        int lat;
        int done_seen;

        vecs[0]  = '{1'b0, 32'd12345,      40'h0000012345, 1'b0, 5,  "s_12345"};
        vecs[1]  = '{1'b0, 32'd0,          40'h0000000000, 1'b0, 1,  "s_zero"};
        vecs[2]  = '{1'b0, 32'hFFFFFFFF,   40'h0000000001, 1'b1, 1,  "s_minus1"};
        vecs[3]  = '{1'b0, 32'h80000000,   40'h2147483648, 1'b1, 10, "s_min"};
        vecs[4]  = '{1'b0, 32'h7FFFFFFF,   40'h2147483647, 1'b0, 10, "s_max"};
        vecs[5]  = '{1'b0, 32'hFFFFCFC7,   40'h0000012345, 1'b1, 5,  "s_m12345"};
        vecs[6]  = '{1'b0, 32'd1000000000, 40'h1000000000, 1'b0, 10, "s_1e9"};
        vecs[7]  = '{1'b0, 32'd10,         40'h0000000010, 1'b0, 2,  "s_10"};
        vecs[8]  = '{1'b1, 32'hFFFFFFFF,   40'h4294967295, 1'b0, 10, "u_max"};
        vecs[9]  = '{1'b1, 32'h80000000,   40'h2147483648, 1'b0, 10, "u_msb"};
        vecs[10] = '{1'b1, 32'd9,          40'h0000000009, 1'b0, 1,  "u_9"};

        bs.start = 1'b0; bs.value = '0;
        bu.start = 1'b0; bu.value = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", bs.ready, 1);
        check("rst done", bs.done, 0);
        check("rst bcd", bs.bcd, 0);
        check("rst negative", bs.negative, 0);
        check("rst num_digits", bs.num_digits, 1);
        check("rst u_ready", bu.ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven conversions
        for (int i = 0; i < 11; i++) begin
            do_conv(vecs[i].uns, vecs[i].value, vecs[i].bcd, vecs[i].neg, vecs[i].nd, vecs[i].name);
        end

        // Start while busy is ignored
        pulse_start(1'b0, 32'd42);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 5) begin bs.start = 1'b1; bs.value = 32'd999; end
            else        bs.start = 1'b0;
            if (bs.done) lat = n;
        end
        bs.start = 1'b0;
        check("ign latency", lat, 33);
        check("ign bcd", bs.bcd, 40'h42);
        check("ign num_digits", bs.num_digits, 2);

        // Back-to-back: start in the done cycle is accepted
        bs.start = 1'b1; bs.value = 32'd100;
        @(posedge clk); #1;
        bs.start = 1'b0;
        check("b2b accepted", bs.ready, 0);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 10) begin
                check("b2b hold bcd", bs.bcd, 40'h42);
                check("b2b hold nd", bs.num_digits, 2);
            end
            if (n == 32) check("b2b hold late", bs.bcd, 40'h42);
            if (bs.done) lat = n;
        end
        check("b2b latency", lat, 33);
        check("b2b bcd", bs.bcd, 40'h100);
        check("b2b num_digits", bs.num_digits, 3);
        @(posedge clk); #1;

        // Reset mid-conversion aborts immediately
        pulse_start(1'b0, 32'd777);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort bcd", bs.bcd, 0);
        check("abort num_digits", bs.num_digits, 1);
        check("abort ready", bs.ready, 1);
        check("abort done", bs.done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (bs.done) done_seen++;
        end
        check("abort no_done", done_seen, 0);
        do_conv(1'b0, 32'd5, 40'h5, 1'b0, 1, "post_rst_5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bin2dec_seq.md
Name: bin2dec_seq

Overview:
- Sequential, parametrised binary-to-decimal converter for on-screen number displays.
- Converts a WIDTH-bit value, signed or unsigned, into packed BCD digits, a sign flag and a significant-digit count.
- Uses iterative double-dabble (shift-and-add-3, one input bit per cycle) instead of a chain of combinational divide-by-10 stages, with a start/ready/done handshake.
- Sits between datapath result registers and the display driver.

Parameters:
- WIDTH, 32, input value width in bits (>=2).
- DIGITS, 10, BCD digits produced. Must be >= ceil(WIDTH*log10(2)); a smaller value is an elaboration-time $error.
- SIGNED, 1, 1 = input is two's complement; 0 = input is unsigned.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of value; accepted only when ready is 1.
- value  input  WIDTH  number to convert; sampled on the accepting edge.
- ready  output  1  block idle, able to accept start.
- done  output  1  one-cycle pulse: results updated.
- bcd  output  4*DIGITS  packed BCD; digit k (units = k=0) at bits [4k+3:4k].
- negative  output  1  1 if SIGNED=1 and the sampled value had its MSB set.
- num_digits  output  clog2(DIGITS+1)  count of significant digits; 1 for zero.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE.
  - ready=1, done=0, bcd=0, negative=0, num_digits=1.
  - Iteration counter, magnitude and BCD shift registers cleared.
- State IDLE:
  - ready=1.
  - On a clk edge with start=1, latch the input:
    - neg = SIGNED & value[WIDTH-1].
    - mag = neg ? (~value + 1) : value, kept as WIDTH-bit unsigned. The most negative value yields magnitude 2^(WIDTH-1), which fits.
    - Working BCD register cleared; counter set to WIDTH; go to SHIFT.
- State SHIFT, one edge per input bit, ready=0:
  - First, every working nibble >=5 has 3 added (all nibbles in parallel).
  - Then {bcd_work, mag} shifts left by 1, so mag's MSB enters digit 0 LSB.
  - Counter decrements. When the counter reaches 1 on this edge, go to FINISH.
- State FINISH, one edge, ready=0:
  - Copy bcd_work to bcd and neg to negative.
  - num_digits = index of the highest non-zero digit + 1, or 1 if all digits are zero.
  - Go to IDLE; done=1 for exactly the following cycle.
- Latency: start accepted at edge E0; results and done=1 visible after edge E(WIDTH+1). With WIDTH=32, done is high 33 cycles after the accepting edge.
- Throughput: one conversion per WIDTH+1 cycles.
  - A start while ready=1 and done=1 is accepted, enabling back-to-back conversions.
- Output hold:
  - bcd, negative and num_digits hold their last results until the next FINISH.
  - They never show intermediate shift values.
- start while ready=0 is ignored: not queued, no effect on the in-flight conversion.
- value changes after the accepting edge have no effect.
- Unsigned mode (SIGNED=0): negative is always 0; full WIDTH range converted.
- Reset mid-conversion: abort immediately, outputs return to reset values, no done pulse.
- Unused high digits (beyond the value's magnitude) read 0.

Test Plan:
- WIDTH=32, SIGNED=1, value=12345, start pulse -> after 33 cycles: done=1 for 1 cycle, bcd=0x0000012345, negative=0, num_digits=5, ready=1.
- value=0 -> bcd=0, num_digits=1, negative=0. value=32'hFFFFFFFF (-1) -> bcd=0x0000000001, negative=1, num_digits=1.
- value=32'h80000000 -> bcd=0x2147483648, negative=1, num_digits=10. value=32'h7FFFFFFF -> bcd=0x2147483647, negative=0.
- SIGNED=0 instance, value=32'hFFFFFFFF -> bcd=0x4294967295, negative=0, num_digits=10.
- Pulse start with 999 at 5 cycles after the initial start of 42 (ignored) -> only the 42 result appears (bcd=0x42, num_digits=2). Then start 100 in the done cycle -> accepted; next done 33 cycles later with bcd=0x100 and num_digits=3; outputs hold 42 until then.
- Assert rst 10 cycles into a conversion of 777 -> outputs go to reset values immediately, no done pulse. After release, a new start of 5 yields bcd=0x5 after 33 cycles.
